// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared operation codes and FSM state type for alu_acc_sequencer
//             and its ALU core.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // Operation codes; identical to the ALU mode encoding
  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational four-mode ALU (a, b, a+b, a-b) with a
//             zero flag. Arithmetic wraps modulo 2^WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             is_zero
);

  // Mode select; carries and borrows fall off the top of the result
  always_comb begin
    y = a;
    case (mode)
      OP_READ: y = a;
      OP_LOAD: y = b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = a;
    endcase
  end

  assign is_zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_acc_sequencer
//  Purpose  : Accepts (op, data) commands over valid/ready, applies each to an
//             internal accumulator through alu_core, writes the result back
//             and presents it with a zero flag on a valid/ready result port.
//             IDLE -> EXEC -> RESP, one command in flight at a time.
//  Options  : define ALU_SEQ_FLAGS_EN to add registered out_carry / out_ovf.
//  Revision : 1.0  initial release
// ============================================================================
module alu_acc_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_is_zero,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             out_carry,
  output logic             out_ovf,
`endif
  output logic [WIDTH-1:0] acc
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_is_zero;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a       (acc),
    .b       (r_data),
    .mode    (r_op),
    .y       (w_alu_y),
    .is_zero (w_alu_is_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; out_ready only steers the state, never in_ready directly
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = EXEC;
      EXEC:    w_state_next = RESP;
      RESP:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == RESP);

  // Command latch in IDLE; result write-back in EXEC; everything holds in RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= OP_READ;
      r_data      <= '0;
      acc         <= '0;
      out_y       <= '0;
      out_is_zero <= 1'b1;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_op   <= in_op;
        r_data <= in_data;
      end
      if (r_state == EXEC) begin
        acc         <= w_alu_y;
        out_y       <= w_alu_y;
        out_is_zero <= w_alu_is_zero;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic w_carry;
  logic w_ovf;

  // ADD carries out exactly when the wrapped sum is below acc; SUB borrows
  // when acc < data. Overflow: operand signs agree (ADD) or differ (SUB) and
  // the result sign departs from acc's sign.
  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_carry = (w_alu_y < acc);
        w_ovf   = (acc[WIDTH-1] == r_data[WIDTH-1]) &&
                  (w_alu_y[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_SUB: begin
        w_carry = (acc < r_data);
        w_ovf   = (acc[WIDTH-1] != r_data[WIDTH-1]) &&
                  (w_alu_y[WIDTH-1] != acc[WIDTH-1]);
      end
      default: begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // Flags are registered alongside out_y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (r_state == EXEC) begin
      out_carry <= w_carry;
      out_ovf   <= w_ovf;
    end
  end
`else
`endif

endmodule
`default_nettype wire
